// File: rtl/axi_mem_word_stream_rd.sv
// Burst-to-stream reader: turns (word address, word count) into sequential single-word
// rd_req/rd_gnt reads and streams the returned words out through a small FWFT FIFO.
module axi_mem_word_stream_rd #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       start_i,
  input  logic [AXI4_ADDR_WIDTH-3:0] start_word_addr_i,
  input  logic [LEN_WIDTH-1:0]       len_words_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       rd_req_o,
  output logic [AXI4_ADDR_WIDTH-3:0] rd_word_addr_o,
  input  logic [AXI4_DATA_WIDTH-1:0] rd_data_i,
  input  logic                       rd_gnt_i,
  output logic [AXI4_DATA_WIDTH-1:0] data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [1:0]                 state_o
);

  localparam int WA = AXI4_ADDR_WIDTH - 2;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       done_q, done_d;
  logic [WA-1:0]              addr_q;
  logic [LEN_WIDTH-1:0]       rem_q;
  logic [AXI4_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count_q;
  logic                       push, pop, accept;

  // Stream handshake: a beat transfers on a rising edge where valid_o and ready_i are both 1;
  // the downstream read transfers where rd_req_o and rd_gnt_i are both 1. rd_req_o comes only
  // from registers, so once raised it holds with a stable address until granted.
  assign rd_req_o       = (state_q == S_REQ) && (rem_q != '0) && (count_q < CW'(FIFO_DEPTH));
  assign push           = rd_req_o & rd_gnt_i;
  assign valid_o        = (count_q != '0);
  assign pop            = valid_o & ready_i;
  assign data_o         = mem[rd_ptr];
  assign rd_word_addr_o = addr_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign state_o        = state_q;
  assign accept         = (state_q == S_IDLE) && start_i && (len_words_i != '0);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_words_i != '0) state_d = S_REQ;
          else                   done_d  = 1'b1;
        end
      end
      S_REQ: begin
        if (push && (rem_q == LEN_WIDTH'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave once the FIFO is empty, counting a pop in this very cycle.
        if ((count_q == '0) || ((count_q == CW'(1)) && pop)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        addr_q <= start_word_addr_i;
        rem_q  <= len_words_i;
      end else if (push) begin
        addr_q <= addr_q + WA'(1);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rd_data_i;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_word_stream_rd.sv
// Directed bench for axi_mem_word_stream_rd: a downstream read model answers requests,
// a scoreboard queue holds expected stream words and a monitor pops/compares each beat.
module tb_axi_mem_word_stream_rd;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int WA = AW - 2;

  logic          ACLK, ARESETn;
  logic          start_i;
  logic [WA-1:0] start_word_addr_i;
  logic [LW-1:0] len_words_i;
  logic          busy_o, done_o, rd_req_o;
  logic [WA-1:0] rd_word_addr_o;
  logic [DW-1:0] rd_data_i;
  logic          rd_gnt_i;
  logic [DW-1:0] data_o;
  logic          valid_o, ready_i;
  logic [1:0]    state_o;

  axi_mem_word_stream_rd #(
    .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start_i(start_i),
    .start_word_addr_i(start_word_addr_i), .len_words_i(len_words_i),
    .busy_o(busy_o), .done_o(done_o), .rd_req_o(rd_req_o),
    .rd_word_addr_o(rd_word_addr_o), .rd_data_i(rd_data_i), .rd_gnt_i(rd_gnt_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .state_o(state_o)
  );

  int            errors = 0;
  int            checks = 0;
  int            done_cnt = 0;
  int            gnt_total = 0;
  int            beat_cnt = 0;
  int            gnt_delay = 3;
  logic [DW-1:0] exp_q[$];
  logic [WA-1:0] exp_addr_q[$];

  // clock / reset
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  function automatic logic [DW-1:0] data_of(input logic [WA-1:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // driver tasks
  task automatic start_cmd(input logic [WA-1:0] addr, input int len, input bit expect_run);
    if (expect_run) begin
      for (int i = 0; i < len; i++) begin
        exp_addr_q.push_back(addr + WA'(i));
        exp_q.push_back(data_of(addr + WA'(i)));
      end
    end
    start_i           = 1'b1;
    start_word_addr_i = addr;
    len_words_i       = LW'(len);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int done_before);
    int n;
    n = 0;
    while (done_cnt == done_before && n < 2000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({name, "_done_once"}, 64'(done_cnt - done_before), 64'd1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'd0);
    check({name, "_busy_low"}, 64'(busy_o), 64'd0);
  endtask

  task automatic wait_stalled(input string name);
    int n;
    n = 0;
    while (!(valid_o && !rd_req_o && busy_o && gnt_total >= 4) && n < 500) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check({name, "_req_held_low"}, 64'(rd_req_o), 64'd0);
    check({name, "_valid_high"}, 64'(valid_o), 64'd1);
  endtask

  // downstream read model
  initial begin
    int            wcnt;
    logic [WA-1:0] held;
    rd_gnt_i  = 1'b0;
    rd_data_i = '0;
    wcnt      = 0;
    held      = '0;
    forever begin
      tick();
      if (!ARESETn) begin
        rd_gnt_i = 1'b0;
        wcnt     = 0;
      end else if (rd_gnt_i) begin
        rd_gnt_i = 1'b0;
      end else if (rd_req_o) begin
        if (wcnt == 0) held = rd_word_addr_o;
        else check("req_addr_hold", 64'(rd_word_addr_o), 64'(held));
        if (wcnt >= gnt_delay) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: addr %0h with no request expected", rd_word_addr_o);
          end else begin
            check("req_addr", 64'(rd_word_addr_o), 64'(exp_addr_q.pop_front()));
          end
          rd_data_i = data_of(rd_word_addr_o);
          rd_gnt_i  = 1'b1;
          gnt_total++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (done_o) done_cnt++;
      if (valid_o && ready_i) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h with nothing expected", data_o);
        end else begin
          check("beat_data", 64'(data_o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int d0, g0, b0;
    ARESETn = 1'b0;
    start_i = 1'b0;
    start_word_addr_i = '0;
    len_words_i = '0;
    ready_i = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_req", 64'(rd_req_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_addr", 64'(rd_word_addr_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    ARESETn = 1'b1;
    repeat (2) tick();

    // 1: basic 4-word burst, slow grants
    ready_i = 1'b1; gnt_delay = 3; d0 = done_cnt; b0 = beat_cnt;
    start_cmd(30'h100, 4, 1'b1);
    check("t1_busy", 64'(busy_o), 64'd1);
    check("t1_state_req", 64'(state_o), 64'd1);
    check("t1_first_addr", 64'(rd_word_addr_o), 64'h100);
    wait_done("t1", d0);
    check("t1_beats", 64'(beat_cnt - b0), 64'd4);

    // 2: consumer stalled, FIFO fills and requests stop
    ready_i = 1'b0; gnt_delay = 1; d0 = done_cnt; g0 = gnt_total; b0 = beat_cnt;
    start_cmd(30'h2000, 8, 1'b1);
    wait_stalled("t2");
    check("t2_grants_when_full", 64'(gnt_total - g0), 64'd4);
    ready_i = 1'b1;
    wait_done("t2", d0);
    check("t2_beats", 64'(beat_cnt - b0), 64'd8);

    // 3: zero-length command
    d0 = done_cnt;
    start_cmd(30'h55, 0, 1'b0);
    check("t3_done_pulse", 64'(done_o), 64'd1);
    check("t3_busy", 64'(busy_o), 64'd0);
    check("t3_req", 64'(rd_req_o), 64'd0);
    tick();
    check("t3_done_low", 64'(done_o), 64'd0);
    check("t3_busy_after", 64'(busy_o), 64'd0);

    // 4: address wraps past all-ones
    gnt_delay = 2; d0 = done_cnt;
    start_cmd(30'h3FFFFFFF, 2, 1'b1);
    wait_done("t4", d0);

    // 5: full FIFO, then push and pop in the same cycle
    ready_i = 1'b0; gnt_delay = 0; d0 = done_cnt; b0 = beat_cnt;
    start_cmd(30'h0ABC, 7, 1'b1);
    wait_stalled("t5");
    ready_i = 1'b1;
    wait_done("t5", d0);
    check("t5_beats", 64'(beat_cnt - b0), 64'd7);

    // 6a: start while busy is ignored
    gnt_delay = 2; d0 = done_cnt;
    start_cmd(30'h200, 5, 1'b1);
    repeat (3) tick();
    start_cmd(30'h900, 3, 1'b0);
    wait_done("t6a", d0);

    // 6b: reset mid-transfer with a request pending
    ready_i = 1'b0; gnt_delay = 6;
    start_cmd(30'h300, 8, 1'b1);
    repeat (2) tick();
    check("t6b_req_before_rst", 64'(rd_req_o), 64'd1);
    #2 ARESETn = 1'b0;
    #1;
    check("t6b_rst_req", 64'(rd_req_o), 64'd0);
    check("t6b_rst_valid", 64'(valid_o), 64'd0);
    check("t6b_rst_busy", 64'(busy_o), 64'd0);
    check("t6b_rst_addr", 64'(rd_word_addr_o), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    tick();
    ARESETn = 1'b1;
    tick();
    ready_i = 1'b1; gnt_delay = 1; d0 = done_cnt; b0 = beat_cnt;
    start_cmd(30'h40, 3, 1'b1);
    wait_done("t6c", d0);
    check("t6c_beats", 64'(beat_cnt - b0), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
